// File: rtl/sap_ctrl_pkg.sv
// Shared opcodes, control-bit indices, microwords and stage encodings for the SAP micro-sequencer.
// The optional conditional jumps (JC/JZ) are enabled by defining CTRL_COND_JMP_EN.
package sap_ctrl_pkg;

   localparam logic [3:0] OP_HLT = 4'h0;
   localparam logic [3:0] OP_NOP = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_LDA = 4'h4;
   localparam logic [3:0] OP_OUT = 4'h5;
   localparam logic [3:0] OP_STA = 4'h6;
   localparam logic [3:0] OP_JMP = 4'h7;
   localparam logic [3:0] OP_JC  = 4'h8;
   localparam logic [3:0] OP_JZ  = 4'h9;

   localparam int CB_PC_INC          = 14;
   localparam int CB_PC_EN           = 13;
   localparam int CB_PC_LOAD         = 12;
   localparam int CB_MAR_ADDR_LOAD_N = 11;
   localparam int CB_MAR_MEM_LOAD_N  = 10;
   localparam int CB_RAM_EN_N        = 9;
   localparam int CB_RAM_LOAD_N      = 8;
   localparam int CB_IR_LOAD_N       = 7;
   localparam int CB_IR_EN_N         = 6;
   localparam int CB_REGA_LOAD_N     = 5;
   localparam int CB_REGA_EN         = 4;
   localparam int CB_ADDER_SUB       = 3;
   localparam int CB_REGB_EN         = 2;
   localparam int CB_REGB_LOAD_N     = 1;
   localparam int CB_OUT_LOAD_N      = 0;

   localparam logic [15:0] CTRL_IDLE = 16'h0FE3;

   // Microwords are 15 bits; the control word is zero-extended above bit 14.
   localparam logic [14:0] MW_IDLE     = 15'h0FE3;
   localparam logic [14:0] MW_T0       = 15'h27E3;
   localparam logic [14:0] MW_T1       = 15'h4FE3;
   localparam logic [14:0] MW_T2       = 15'h0D63;
   localparam logic [14:0] MW_ADDR_IR  = 15'h07A3;
   localparam logic [14:0] MW_LDA_T4   = 15'h0DC3;
   localparam logic [14:0] MW_ADD_T4   = 15'h0DE1;
   localparam logic [14:0] MW_ADD_T5   = 15'h0FC7;
   localparam logic [14:0] MW_SUB_T5   = 15'h0FCF;
   localparam logic [14:0] MW_STA_T4   = 15'h0BF3;
   localparam logic [14:0] MW_STA_T5   = 15'h0EE3;
   localparam logic [14:0] MW_OUT_T3   = 15'h0FF2;
   localparam logic [14:0] MW_JMP_T3   = 15'h1FA3;

   localparam int T0 = 0;
   localparam int T1 = 1;
   localparam int T2 = 2;
   localparam int T3 = 3;
   localparam int T4 = 4;
   localparam int T5 = 5;

   typedef enum logic {ST_RUN, ST_HALTED} seq_mode_e;

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode: (stage, opcode, flags) -> microword, last-stage and halt flags.
// JC/JZ decode only when CTRL_COND_JMP_EN is defined; otherwise they fall through to NOP.
module sap_microcode_rom
   import sap_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 4,
   parameter int STAGE_W  = 3
) (
   input  logic [STAGE_W-1:0]  i_stage,
   input  logic [OPCODE_W-1:0] i_opcode,
   input  logic                i_flag_c,
   input  logic                i_flag_z,
   output logic [14:0]         o_cw,
   output logic                o_last,
   output logic                o_hlt
);

   logic [OPCODE_W-1:0] w_op_hi;
   logic [3:0]          w_op;

   // Any set bit above bit 3 turns the opcode into a NOP.
   assign w_op_hi = i_opcode >> 4;
   assign w_op    = (w_op_hi == '0) ? i_opcode[3:0] : OP_NOP;

`ifndef CTRL_COND_JMP_EN
   logic w_unused_flags;
   assign w_unused_flags = i_flag_c ^ i_flag_z;
`endif

   always_comb begin
      o_cw   = MW_IDLE;
      o_last = 1'b1;
      o_hlt  = 1'b0;
      case (i_stage)
         STAGE_W'(T0): begin o_cw = MW_T0; o_last = 1'b0; end
         STAGE_W'(T1): begin o_cw = MW_T1; o_last = 1'b0; end
         STAGE_W'(T2): begin o_cw = MW_T2; o_last = 1'b0; end
         STAGE_W'(T3): begin
            case (w_op)
               OP_HLT: o_hlt = 1'b1;
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin o_cw = MW_ADDR_IR; o_last = 1'b0; end
               OP_OUT: o_cw = MW_OUT_T3;
               OP_JMP: o_cw = MW_JMP_T3;
`ifdef CTRL_COND_JMP_EN
               OP_JC:  o_cw = i_flag_c ? MW_JMP_T3 : MW_IDLE;
               OP_JZ:  o_cw = i_flag_z ? MW_JMP_T3 : MW_IDLE;
`endif
               default: o_cw = MW_IDLE;
            endcase
         end
         STAGE_W'(T4): begin
            case (w_op)
               OP_LDA: o_cw = MW_LDA_T4;
               OP_ADD, OP_SUB: begin o_cw = MW_ADD_T4; o_last = 1'b0; end
               OP_STA: begin o_cw = MW_STA_T4; o_last = 1'b0; end
               default: o_cw = MW_IDLE;
            endcase
         end
         STAGE_W'(T5): begin
            case (w_op)
               OP_ADD:  o_cw = MW_ADD_T5;
               OP_SUB:  o_cw = MW_SUB_T5;
               OP_STA:  o_cw = MW_STA_T5;
               default: o_cw = MW_IDLE;
            endcase
         end
         default: o_cw = MW_IDLE;
      endcase
   end

endmodule

// File: rtl/sap_microsequencer.sv
// SAP micro-sequencer: stage counter, run/single-step control, HALTED state, control-word drive.
// Define CTRL_COND_JMP_EN to enable the JC/JZ conditional jumps in the microcode ROM.
module sap_microsequencer
   import sap_ctrl_pkg::*;
#(
   parameter  int OPCODE_W = 4,
   parameter  int CW_W     = 16,
   parameter  int NUM_T    = 6,
   localparam int STAGE_W  = $clog2(NUM_T)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                run,
   input  logic                step,
   input  logic                flag_c,
   input  logic                flag_z,
   output logic [CW_W-1:0]     ctrl,
   output logic [STAGE_W-1:0]  stage,
   output logic                halted,
   output logic                instr_done
);

   logic [STAGE_W-1:0] r_stage;
   seq_mode_e          r_mode;
   logic               r_step_q;

   logic [14:0] w_cw;
   logic        w_last;
   logic        w_hlt;
   logic        w_active;
   logic        w_bad_stage;
   logic        w_halted;
   logic        w_drive;

   sap_microcode_rom #(
      .OPCODE_W (OPCODE_W),
      .STAGE_W  (STAGE_W)
   ) u_rom (
      .i_stage  (r_stage),
      .i_opcode (opcode),
      .i_flag_c (flag_c),
      .i_flag_z (flag_z),
      .o_cw     (w_cw),
      .o_last   (w_last),
      .o_hlt    (w_hlt)
   );

   // In step mode only the cycle carrying a fresh step edge executes.
   assign w_active    = run | (step & ~r_step_q);
   assign w_bad_stage = (r_stage > STAGE_W'(T5));
   assign w_halted    = (r_mode == ST_HALTED);
   assign w_drive     = ~rst & ~w_halted & w_active & ~w_bad_stage;

   assign ctrl       = w_drive ? CW_W'(w_cw) : CW_W'(MW_IDLE);
   assign instr_done = w_drive & w_last;
   assign stage      = r_stage;
   assign halted     = w_halted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stage  <= '0;
         r_mode   <= ST_RUN;
         r_step_q <= 1'b0;
      end else begin
         r_step_q <= step;
         if (w_bad_stage) begin
            r_stage <= '0;
         end else if (r_mode == ST_RUN && w_active) begin
            // HLT parks at T3; only rst leaves HALTED.
            if (w_hlt)       r_mode  <= ST_HALTED;
            else if (w_last) r_stage <= '0;
            else             r_stage <= r_stage + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sap_microsequencer.sv
// Randomized self-checking bench for sap_microsequencer against an instruction-table reference model.
// Honors CTRL_COND_JMP_EN the same way as the RTL build.
module tb_sap_microsequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  opcode = 4'h1;
   logic        run = 1'b0;
   logic        step = 1'b0;
   logic        flag_c = 1'b0;
   logic        flag_z = 1'b0;
   logic [15:0] ctrl;
   logic [2:0]  stage;
   logic        halted;
   logic        instr_done;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state: position within the current instruction
   int m_pos    = 0;
   bit m_halted = 1'b0;
   bit m_stepq  = 1'b0;
   logic [15:0] last_ctrl;

   sap_microsequencer dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .run        (run),
      .step       (step),
      .flag_c     (flag_c),
      .flag_z     (flag_z),
      .ctrl       (ctrl),
      .stage      (stage),
      .halted     (halted),
      .instr_done (instr_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int ins_len(input logic [3:0] op);
      case (op)
         4'h4:             return 5;
         4'h2, 4'h3, 4'h6: return 6;
         default:          return 4;
      endcase
   endfunction

   function automatic logic [15:0] ins_word(input logic [3:0] op, input int pos,
                                            input bit fc, input bit fz);
      if (pos == 0) return 16'h27E3;
      if (pos == 1) return 16'h4FE3;
      if (pos == 2) return 16'h0D63;
      case (op)
         4'h4: return (pos == 3) ? 16'h07A3 : 16'h0DC3;
         4'h2: return (pos == 3) ? 16'h07A3 : (pos == 4) ? 16'h0DE1 : 16'h0FC7;
         4'h3: return (pos == 3) ? 16'h07A3 : (pos == 4) ? 16'h0DE1 : 16'h0FCF;
         4'h6: return (pos == 3) ? 16'h07A3 : (pos == 4) ? 16'h0BF3 : 16'h0EE3;
         4'h5: return 16'h0FF2;
         4'h7: return 16'h1FA3;
`ifdef CTRL_COND_JMP_EN
         4'h8: return fc ? 16'h1FA3 : 16'h0FE3;
         4'h9: return fz ? 16'h1FA3 : 16'h0FE3;
`endif
         default: return 16'h0FE3;
      endcase
   endfunction

   // One clock cycle: called just after a rising edge, drives inputs, checks mid-cycle,
   // advances the model, and returns just after the next rising edge.
   task automatic cyc(input bit r, input bit s, input logic [3:0] op, input bit fc, input bit fz);
      bit          act;
      bit          done;
      logic [15:0] ew;
      run = r; step = s; opcode = op; flag_c = fc; flag_z = fz;
      @(negedge clk);
      act = r | (s & ~m_stepq);
      ew = 16'h0FE3;
      done = 1'b0;
      if (!m_halted && act) begin
         ew   = ins_word(op, m_pos, fc, fz);
         done = (m_pos == ins_len(op) - 1);
      end
      last_ctrl = ctrl;
      chk("ctrl", {16'h0, ctrl}, {16'h0, ew});
      chk("stage", {29'h0, stage}, m_halted ? 32'd3 : m_pos);
      chk("halted", {31'h0, halted}, {31'h0, m_halted});
      chk("instr_done", {31'h0, instr_done}, {31'h0, done});
      m_stepq = s;
      if (!m_halted && act) begin
         if (done) begin
            if (op == 4'h0) m_halted = 1'b1;
            else            m_pos = 0;
         end else begin
            m_pos++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset asserted mid-cycle, released just after the next rising edge.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_ctrl", {16'h0, ctrl}, 32'h0FE3);
      chk("rst_stage", {29'h0, stage}, 32'd0);
      chk("rst_halted", {31'h0, halted}, 32'd0);
      chk("rst_done", {31'h0, instr_done}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      m_pos = 0; m_halted = 1'b0; m_stepq = 1'b0;
   endtask

   logic [15:0] lda_exp [6] = '{16'h27E3, 16'h4FE3, 16'h0D63, 16'h07A3, 16'h0DC3, 16'h27E3};
   logic [3:0]  cur_op;
   int          halt_cnt;
   logic [2:0]  stage_before;

   initial begin
      #1;
      do_reset();

      // LDA free-run
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b0, 4'h4, 1'b0, 1'b0);
         chk("lda_seq", {16'h0, last_ctrl}, {16'h0, lda_exp[i]});
      end
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 4'h4, 1'b0, 1'b0);

      // SUB, then OUT
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
      chk("sub_t5", {16'h0, last_ctrl}, 32'h0FCF);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 4'h5, 1'b0, 1'b0);
      chk("out_end_stage", {29'h0, stage}, 32'd0);

      // conditional jump / fallback
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 4'h9, 1'b0, 1'b1);
`ifdef CTRL_COND_JMP_EN
      chk("jz_taken", {16'h0, last_ctrl}, 32'h1FA3);
`else
      chk("op9_nop", {16'h0, last_ctrl}, 32'h0FE3);
`endif
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 4'h9, 1'b0, 1'b0);
      chk("jz_not_taken", {16'h0, last_ctrl}, 32'h0FE3);

      // HLT with run/step toggling
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      for (int i = 0; i < 24; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'h0, 1'b0, 1'b0);
      chk("hlt_halted", {31'h0, halted}, 32'd1);
      do_reset();

      // step mode: three step pulses, one held for 5 cycles
      stage_before = stage;
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'h4, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 4'h4, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 4'h4, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 4'h4, 1'b0, 1'b0);
      chk("step_adv", {29'h0, stage}, {29'h0, stage_before} + 32'd3);
      for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 4'h4, 1'b0, 1'b0);

      // async reset mid-T4 of STA
      while (m_pos != 0) cyc(1'b1, 1'b0, 4'h4, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 4'h6, 1'b0, 1'b0);
      chk("sta_in_t4", {29'h0, stage}, 32'd4);
      do_reset();
      cyc(1'b1, 1'b0, 4'h6, 1'b0, 1'b0);
      chk("post_rst_t0", {16'h0, last_ctrl}, 32'h27E3);

      // randomized run
      cur_op = 4'h4;
      halt_cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         if (m_pos == 0 && !m_halted) begin
            cur_op = 4'($urandom_range(0, 15));
            if (cur_op == 4'h0 && $urandom_range(0, 3) != 0) cur_op = 4'h7;
         end
         cyc(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), cur_op,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if (m_halted) halt_cnt++;
         if (halt_cnt > 6) begin
            halt_cnt = 0;
            do_reset();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sap_microsequencer.md
Name: sap_microsequencer

Overview:
- Parametrised micro-sequencer for the 8-bit CPU.
- Steps through fetch stages T0-T2 and opcode-dependent execute stages T3-T5, and drives the control word to PC, MAR, RAM, IR, A, B, ALU and OUT.
- Adds variable-length instructions with early return to T0, a HALTED state, and run/single-step control.

Parameters:
- OPCODE_W, 4: opcode width; must be 4 or more. Any nonzero bit above bit 3 decodes as NOP.
- CW_W, 16: control word width; must be 15 or more. Bits 15 and up are always 0.
- NUM_T, 6: number of micro-stages; must be 6 or more. STAGE_W = $clog2(NUM_T).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  OPCODE_W  IR opcode field; must be stable from T3 until the instruction ends.
- run  in  1  1 = free-run; 0 = step mode.
- step  in  1  step request, synchronous level; rising edge detected internally.
- flag_c  in  1  ALU carry; used only with CTRL_COND_JMP_EN.
- flag_z  in  1  ALU zero; used only with CTRL_COND_JMP_EN.
- ctrl  out  CW_W  control word. Bit map: 14 PC_INC, 13 PC_EN, 12 PC_LOAD, 11 MAR_ADDR_LOAD_N, 10 MAR_MEM_LOAD_N, 9 RAM_EN_N, 8 RAM_LOAD_N, 7 IR_LOAD_N, 6 IR_EN_N, 5 REGA_LOAD_N, 4 REGA_EN, 3 ADDER_SUB, 2 REGB_EN, 1 REGB_LOAD_N, 0 OUT_LOAD_N.
- stage  out  STAGE_W  current micro-stage.
- halted  out  1  high in the HALTED state.
- instr_done  out  1  one-cycle pulse on the last micro-step of an instruction.

Behaviour:
- Reset: stage=0, halted=0, instr_done=0, step edge detector cleared. While rst=1, ctrl=CTRL_IDLE=16'h0FE3 (all _N bits high, everything else low).
- A reset mid-instruction abandons the instruction. The first cycle after release is T0.
- ctrl is a combinational decode of registered stage, halted, pause status and opcode.
- Advancing:
  - run=1: advance every cycle.
  - run=0: ctrl=CTRL_IDLE and stage holds. A detected step rising edge makes the current stage word drive for exactly that cycle, then stage advances.
  - Holding step high gives one advance only.
- Fetch words:
  - T0 = 16'h27E3
  - T1 = 16'h4FE3
  - T2 = 16'h0D63
- Execute words and the instruction's last stage:
  - LDA 4'h4: T3 07A3, T4 0DC3; ends at T4.
  - ADD 4'h2: T3 07A3, T4 0DE1, T5 0FC7; ends at T5.
  - SUB 4'h3: same as ADD except T5 = 0FCF; ends at T5.
  - STA 4'h6: T3 07A3, T4 0BF3, T5 0EE3; ends at T5.
  - OUT 4'h5: T3 0FF2; ends at T3.
  - JMP 4'h7: T3 1FA3; ends at T3.
  - NOP 4'h1 and all undefined opcodes: T3 0FE3; ends at T3.
- End of instruction: instr_done=1 in the last stage, and the next stage is T0. There are no idle stages between instructions.
- HLT 4'h0:
  - At T3, ctrl=CTRL_IDLE and instr_done=1; the next state is HALTED.
  - In HALTED: stage=T3 held, halted=1, ctrl=CTRL_IDLE. run and step are ignored.
  - The only exit is rst.
- Stage values at or above NUM_T are unreachable. If reached anyway, they recover to T0 with ctrl=CTRL_IDLE.
- run falling in the middle of an instruction pauses at the next edge without loss; run=1 resumes from the held stage.

Optional Feature:
- Macro: CTRL_COND_JMP_EN.
- Defined:
  - JC 4'h8: T3 = 1FA3 if flag_c=1, else 0FE3. Flags are sampled in T3. Ends at T3.
  - JZ 4'h9: same as JC, using flag_z.
- Undefined: 4'h8 and 4'h9 decode as NOP, and flag_c/flag_z are unused.

Decomposition:
- Package sap_ctrl_pkg holds:
  - opcode localparams
  - control-bit index localparams
  - CTRL_IDLE and the named microword constants
  - stage encodings T0..T5
- Sub-module sap_microcode_rom: purely combinational (stage, opcode, flags) -> (ctrl word, last-stage flag).
- The sequencer keeps the state, the step edge detector and the halt logic.

Test Plan:
- Reset, then free-run with opcode=4'h4 -> ctrl sequence 27E3, 4FE3, 0D63, 07A3, 0DC3, then 27E3; instr_done high only in the 0DC3 cycle.
- Opcode 4'h3 -> T5 = 0FCF. Opcode 4'h5 -> 4-cycle instruction, 0FF2 at T3, next cycle T0.
- Opcode 4'h0 -> halted=1 from the cycle after T3 and ctrl=0FE3 for 20+ cycles, with run and step toggling. Asserting rst then gives stage=0 and halted=0.
- run=0 with three step pulses, one held high for 5 cycles -> exactly three advances, and ctrl=0FE3 on all non-step cycles.
- rst asserted asynchronously mid-T4 of STA -> ctrl=0FE3 immediately and stage=0; after release, the T0 word is 27E3.
- With CTRL_COND_JMP_EN: JZ with flag_z=1 -> 1FA3; JZ with flag_z=0 -> 0FE3. Without the macro, 4'h9 -> 0FE3.
